// File: rtl/debug_report_tx.sv
// rtl/debug_report_tx.sv - streams a PC/GPR/data-memory/cycle-count debug report as UART tx bytes
// Words go MSB byte first; PC and cycle count come from a snapshot taken when the report is accepted.
module debug_report_tx #(
  parameter int BYTE     = 8,
  parameter int DWORD    = 32,
  parameter int RB_ADDR  = 5,
  parameter int MEM_ADDR = 5
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [DWORD-1:0]    i_pc,
  input  logic [DWORD-1:0]    i_cycles,
  output logic [RB_ADDR-1:0]  o_rb_addr,
  input  logic [DWORD-1:0]    i_rb_data,
  output logic [MEM_ADDR-1:0] o_mem_addr,
  input  logic [DWORD-1:0]    i_mem_data,
  output logic [BYTE-1:0]     o_tx_data,
  output logic                o_tx_start,
  input  logic                i_tx_done,
  output logic                o_busy,
  output logic                o_done
);

  localparam int NB = DWORD / BYTE;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int WW = ((RB_ADDR > MEM_ADDR) ? RB_ADDR : MEM_ADDR) + 1;
  localparam logic [WW-1:0] RB_LAST  = WW'((1 << RB_ADDR) - 1);
  localparam logic [WW-1:0] MEM_LAST = WW'((1 << MEM_ADDR) - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_SEND, S_WAIT, S_NEXT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_PC, PH_REGS, PH_MEM, PH_CYC
  } phase_t;

  state_t              state_q;
  phase_t              phase_q;
  logic [WW-1:0]       word_q;
  logic [BW-1:0]       byte_q;
  logic [DWORD-1:0]    pc_q;
  logic [DWORD-1:0]    cyc_q;
  logic [DWORD-1:0]    shift_q;
  logic [BYTE-1:0]     tx_data_q;
  logic                tx_start_q;
  logic                busy_q;
  logic                done_q;
  logic [RB_ADDR-1:0]  rb_addr_q;
  logic [MEM_ADDR-1:0] mem_addr_q;

  logic                word_last_d;
  phase_t              phase_d;
  logic [WW-1:0]       word_d;
  logic [DWORD-1:0]    src_d;

  always_comb begin
    word_last_d = 1'b1;
    src_d       = pc_q;
    case (phase_q)
      PH_PC:   begin word_last_d = 1'b1;                 src_d = pc_q;       end
      PH_REGS: begin word_last_d = (word_q == RB_LAST);  src_d = i_rb_data;  end
      PH_MEM:  begin word_last_d = (word_q == MEM_LAST); src_d = i_mem_data; end
      PH_CYC:  begin word_last_d = 1'b1;                 src_d = cyc_q;      end
      default: begin word_last_d = 1'b1;                 src_d = pc_q;       end
    endcase
    phase_d = phase_q;
    word_d  = word_q + WW'(1);
    if (word_last_d) begin
      phase_d = phase_t'(phase_q + 2'd1);
      word_d  = '0;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_PC;
      word_q     <= '0;
      byte_q     <= '0;
      pc_q       <= '0;
      cyc_q      <= '0;
      shift_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rb_addr_q  <= '0;
      mem_addr_q <= '0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            pc_q    <= i_pc;
            cyc_q   <= i_cycles;
            phase_q <= PH_PC;
            word_q  <= '0;
            byte_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        // Source data is valid here because the address was set on entry to FETCH.
        S_LATCH: begin
          shift_q    <= src_d;
          tx_data_q  <= src_d[DWORD-1 -: BYTE];
          tx_start_q <= 1'b1;
          state_q    <= S_SEND;
        end
        S_SEND: state_q <= S_WAIT;
        S_WAIT: begin
          if (i_tx_done) state_q <= S_NEXT;
        end
        S_NEXT: begin
          if (byte_q != BYTE_LAST) begin
            byte_q     <= byte_q + BW'(1);
            shift_q    <= shift_q << BYTE;
            tx_data_q  <= shift_q[DWORD-BYTE-1 -: BYTE];
            tx_start_q <= 1'b1;
            state_q    <= S_SEND;
          end else begin
            byte_q <= '0;
            if (word_last_d && phase_q == PH_CYC) begin
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              phase_q <= phase_d;
              word_q  <= word_d;
              if (phase_d == PH_REGS) rb_addr_q  <= word_d[RB_ADDR-1:0];
              if (phase_d == PH_MEM)  mem_addr_q <= word_d[MEM_ADDR-1:0];
              state_q <= S_FETCH;
            end
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_rb_addr  = rb_addr_q;
  assign o_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_debug_report_tx.sv
// tb/tb_debug_report_tx.sv - scoreboard bench for debug_report_tx
module tb_debug_report_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_pc;
  logic [31:0] i_cycles;
  logic [4:0]  rb_addr;
  logic [31:0] rb_data;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        i_tx_done;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cnt = 0;
  int byte_no = 0;
  int rep_base = 0;
  int done_total = 0;
  int done_base = 0;
  int last_done_cnt = 0;
  int start_cnt = 0;
  int done_pulses = 0;
  int stall_idx = 50;
  int spur_idx = 10;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  debug_report_tx dut (
    .i_clock(clk), .i_reset(rst), .i_start(i_start), .i_pc(i_pc), .i_cycles(i_cycles),
    .o_rb_addr(rb_addr), .i_rb_data(rb_data), .o_mem_addr(mem_addr), .i_mem_data(mem_data),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(i_tx_done),
    .o_busy(busy), .o_done(done)
  );

  always @(posedge clk) begin
    cnt      <= cnt + 1;
    rb_data  <= 32'h01010101 * {27'd0, rb_addr};
    mem_data <= 32'hA5000000 | {27'd0, mem_addr};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_report(input logic [31:0] pc, input logic [31:0] cy);
    logic [31:0] w;
    for (int k = 0; k < 66; k++) begin
      if (k == 0) w = pc;
      else if (k <= 32) w = 32'h01010101 * (k - 1);
      else if (k <= 64) w = 32'hA5000000 | (k - 33);
      else w = cy;
      for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
    end
  endtask

  task automatic tx_agent();
    int idx, n, bad;
    logic [7:0] hold, e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        idx = byte_no - rep_base;
        if (exp_q.size() == 0) check("extra_byte", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("tx_byte", {24'd0, tx_data}, {24'd0, e});
        end
        if (idx == 0) check("first_latency", cnt, start_cnt + 3);
        else if (done_total > done_base)
          check("gap_idle", cnt - last_done_cnt - 1, (idx % 4 == 0) ? 3 : 1);
        byte_no++;
        hold = tx_data;
        n = (idx == stall_idx) ? 1000 : 5;
        bad = 0;
        if (idx == spur_idx) begin
          i_tx_done = 1'b1;
          @(posedge clk);
          #1 i_tx_done = 1'b0;
        end
        for (int k = 1; k < n; k++) begin
          @(negedge clk);
          if (tx_start || tx_data !== hold) bad++;
        end
        if (n == 1000) check("stall_hold", bad, 0);
        @(posedge clk);
        #1 i_tx_done = 1'b1;
        @(negedge clk);
        last_done_cnt = cnt;
        done_total++;
        @(posedge clk);
        #1 i_tx_done = 1'b0;
      end
    end
  endtask

  task automatic launch(input logic [31:0] pc, input logic [31:0] cy);
    i_pc      = pc;
    i_cycles  = cy;
    rep_base  = byte_no;
    done_base = done_total;
    push_report(pc, cy);
    @(posedge clk);
    #1 i_start = 1'b1;
    start_cnt = cnt;
    @(posedge clk);
    #1 i_start = 1'b0;
    @(negedge clk);
    check("busy_after_accept", {31'd0, busy}, 1);
  endtask

  task automatic wait_idx(input int target);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (byte_no - rep_base >= target) return;
    end
    check("wait_byte_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int extra;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if (done) begin
        done_pulses++;
        check("start_count", byte_no - rep_base, 264);
        check("done_timing", cnt, last_done_cnt + 2);
        check("queue_drained", exp_q.size(), 0);
        check("busy_at_done", {31'd0, busy}, 0);
        extra = 0;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          if (done || tx_start) extra++;
        end
        check("quiet_after_done", extra, 0);
        return;
      end
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, {24'd0, tx_data}, 0);
    check({tag, "_tx_start"}, {31'd0, tx_start}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_done"}, {31'd0, done}, 0);
    check({tag, "_rb_addr"}, {27'd0, rb_addr}, 0);
    check({tag, "_mem_addr"}, {27'd0, mem_addr}, 0);
  endtask

  initial begin
    rst       = 1'b1;
    i_start   = 1'b0;
    i_pc      = 32'h0;
    i_cycles  = 32'h0;
    i_tx_done = 1'b0;
    fork
      tx_agent();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    repeat (2) @(posedge clk);
    #1 i_tx_done = 1'b1;
    @(posedge clk);
    #1 i_tx_done = 1'b0;
    @(negedge clk);
    check("idle_spur_busy", {31'd0, busy}, 0);
    check("idle_spur_start", {31'd0, tx_start}, 0);

    launch(32'h00000010, 32'h0000012C);
    wait_idx(21);
    #1 i_pc = 32'hFFFFFFFF;
    i_cycles = 32'hFFFFFFFF;
    i_start  = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    wait_done();
    check("report1_done_pulses", done_pulses, 1);
    check("idle_holds_tx_data", {24'd0, tx_data}, 32'h2C);

    stall_idx = -1;
    spur_idx  = -1;
    launch(32'h00000020, 32'h00000055);
    wait_idx(101);
    #3 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("no_resume_busy", {31'd0, busy}, 0);
    check("no_resume_bytes", byte_no - rep_base, 101);
    exp_q.delete();

    launch(32'h00400000, 32'hDEADBEEF);
    wait_done();
    check("report3_done_pulses", done_pulses, 2);
    check("report3_last_byte", {24'd0, tx_data}, 32'hEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
